// File: rtl/snn_defs_pkg.sv
// Shared SNN definitions: default datapath sizes and sequencer state encodings.
package snn_defs_pkg;

    localparam int unsigned SNN_SIZE        = 8;
    localparam int unsigned SNN_NUM_NEURONS = 16;
    localparam int unsigned SNN_NUM_INPUTS  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ACCUM = 3'd2,
        DECAY = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/neuron.sv
// Single leaky integrate-and-fire neuron datapath (combinational).
// Ports:
//   function_sel  0 = accumulate (v_mem_in + weight), 1 = decay and fire
//   weight        synaptic weight added during accumulate
//   v_mem_in      current membrane voltage
//   beta          decay multiplier
//   v_th          firing threshold (unsigned, strict compare)
//   v_mem_out     updated membrane voltage
//   spike         fire indication (decay mode only)
module neuron #(
    parameter int unsigned SIZE = 8
) (
    input  logic            function_sel,
    input  logic [SIZE-1:0] weight,
    input  logic [SIZE-1:0] v_mem_in,
    input  logic [SIZE-1:0] beta,
    input  logic [SIZE-1:0] v_th,
    output logic [SIZE-1:0] v_mem_out,
    output logic            spike
);

    logic [SIZE-1:0] decayed;

    // Product is evaluated at SIZE bits, so it wraps modulo 2^SIZE.
    always_comb begin
        decayed   = v_mem_in * beta;
        v_mem_out = v_mem_in + weight;
        spike     = 1'b0;
        if (function_sel) begin
            spike     = (decayed > v_th);
            v_mem_out = spike ? '0 : decayed;
        end
    end

endmodule

// File: rtl/neuron_sequencer.sv
// Time-multiplexes NUM_NEURONS neurons over one neuron datapath. Each timestep
// walks every (neuron, input) pair: fetch weight, accumulate if the input
// spiked, then one decay/fire step per neuron.
// Ports:
//   wb_clk_i, wb_rst_i  clock, async active-high reset
//   start, clear_vmem   begin a timestep / zero all membrane voltages (IDLE only)
//   in_spikes           input spike vector, latched at start
//   cfg_beta, cfg_v_th  decay factor and threshold, latched at start
//   weight_addr/_re     weight memory read request (j*NUM_INPUTS+i)
//   weight_data         read data, one cycle after weight_re
//   out_spikes          spikes of the last completed timestep
//   busy, done          timestep in progress / one-cycle completion pulse
module neuron_sequencer
    import snn_defs_pkg::*;
#(
    parameter  int unsigned SIZE        = SNN_SIZE,
    parameter  int unsigned NUM_NEURONS = SNN_NUM_NEURONS,
    parameter  int unsigned NUM_INPUTS  = SNN_NUM_INPUTS,
    localparam int unsigned ADDR_W      = $clog2(NUM_NEURONS * NUM_INPUTS)
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   start,
    input  logic                   clear_vmem,
    input  logic [NUM_INPUTS-1:0]  in_spikes,
    input  logic [SIZE-1:0]        cfg_beta,
    input  logic [SIZE-1:0]        cfg_v_th,
    output logic [ADDR_W-1:0]      weight_addr,
    output logic                   weight_re,
    input  logic [SIZE-1:0]        weight_data,
    output logic [NUM_NEURONS-1:0] out_spikes,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned I_W = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
    localparam int unsigned J_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [I_W-1:0] I_LAST = I_W'(NUM_INPUTS - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(NUM_NEURONS - 1);

    seq_state_e             state_q, state_d;
    logic [I_W-1:0]         i_q, i_d;
    logic [J_W-1:0]         j_q, j_d;
    logic [NUM_INPUTS-1:0]  spikes_q, spikes_d;
    logic [SIZE-1:0]        beta_q, beta_d;
    logic [SIZE-1:0]        v_th_q, v_th_d;
    logic [SIZE-1:0]        vmem_q [NUM_NEURONS];
    logic [SIZE-1:0]        vmem_d [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] pending_q, pending_d;
    logic [NUM_NEURONS-1:0] out_spikes_q, out_spikes_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   weight_re_q, weight_re_d;
    logic [ADDR_W-1:0]      weight_addr_q, weight_addr_d;

    logic                   function_sel_c;
    logic [SIZE-1:0]        v_mem_out_c;
    logic                   spike_c;

    neuron #(
        .SIZE (SIZE)
    ) u_neuron (
        .function_sel (function_sel_c),
        .weight       (weight_data),
        .v_mem_in     (vmem_q[j_q]),
        .beta         (beta_q),
        .v_th         (v_th_q),
        .v_mem_out    (v_mem_out_c),
        .spike        (spike_c)
    );

    // State and datapath registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q       <= IDLE;
            i_q           <= '0;
            j_q           <= '0;
            spikes_q      <= '0;
            beta_q        <= '0;
            v_th_q        <= '0;
            pending_q     <= '0;
            out_spikes_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            weight_re_q   <= 1'b0;
            weight_addr_q <= '0;
            for (int n = 0; n < int'(NUM_NEURONS); n++) begin
                vmem_q[n] <= '0;
            end
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            spikes_q      <= spikes_d;
            beta_q        <= beta_d;
            v_th_q        <= v_th_d;
            pending_q     <= pending_d;
            out_spikes_q  <= out_spikes_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            weight_re_q   <= weight_re_d;
            weight_addr_q <= weight_addr_d;
            vmem_q        <= vmem_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d        = state_q;
        i_d            = i_q;
        j_d            = j_q;
        spikes_d       = spikes_q;
        beta_d         = beta_q;
        v_th_d         = v_th_q;
        vmem_d         = vmem_q;
        pending_d      = pending_q;
        out_spikes_d   = out_spikes_q;
        function_sel_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Clear lands before the timestep's first accumulate.
                if (clear_vmem) begin
                    for (int n = 0; n < int'(NUM_NEURONS); n++) begin
                        vmem_d[n] = '0;
                    end
                end
                if (start) begin
                    spikes_d = in_spikes;
                    beta_d   = cfg_beta;
                    v_th_d   = cfg_v_th;
                    i_d      = '0;
                    j_d      = '0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                state_d = ACCUM;
            end
            ACCUM: begin
                if (spikes_q[i_q]) begin
                    vmem_d[j_q] = v_mem_out_c;
                end
                if (i_q == I_LAST) begin
                    state_d = DECAY;
                end else begin
                    i_d     = i_q + I_W'(1);
                    state_d = FETCH;
                end
            end
            DECAY: begin
                function_sel_c = 1'b1;
                vmem_d[j_q]    = v_mem_out_c;
                pending_d[j_q] = spike_c;
                if (j_q == J_LAST) begin
                    state_d = DONE;
                end else begin
                    j_d     = j_q + J_W'(1);
                    i_d     = '0;
                    state_d = FETCH;
                end
            end
            DONE: begin
                out_spikes_d = pending_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs track the state being entered so they align with it.
        busy_d        = (state_d != IDLE);
        done_d        = (state_q == DONE);
        weight_re_d   = (state_d == FETCH);
        weight_addr_d = ADDR_W'(j_d) * ADDR_W'(NUM_INPUTS) + ADDR_W'(i_d);
    end

    assign weight_addr = weight_addr_q;
    assign weight_re   = weight_re_q;
    assign out_spikes  = out_spikes_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer with a one-cycle-latency weight memory.
module tb_neuron_sequencer;

    localparam int unsigned SIZE = 8;
    localparam int unsigned NN   = 16;
    localparam int unsigned NI   = 16;
    localparam int unsigned AW   = 8;
    localparam int          LAT  = 529;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic            start;
    logic            clear_vmem;
    logic [NI-1:0]   in_spikes;
    logic [SIZE-1:0] cfg_beta;
    logic [SIZE-1:0] cfg_v_th;
    logic [AW-1:0]   weight_addr;
    logic            weight_re;
    logic [SIZE-1:0] weight_data = '0;
    logic [NN-1:0]   out_spikes;
    logic            busy;
    logic            done;

    logic [SIZE-1:0] wmem [NN*NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    neuron_sequencer dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .start       (start),
        .clear_vmem  (clear_vmem),
        .in_spikes   (in_spikes),
        .cfg_beta    (cfg_beta),
        .cfg_v_th    (cfg_v_th),
        .weight_addr (weight_addr),
        .weight_re   (weight_re),
        .weight_data (weight_data),
        .out_spikes  (out_spikes),
        .busy        (busy),
        .done        (done)
    );

    always @(posedge wb_clk_i) begin
        if (weight_re) weight_data <= wmem[weight_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic load(input logic [SIZE-1:0] w, input logic [NI-1:0] sp,
                        input logic [SIZE-1:0] b, input logic [SIZE-1:0] th);
        for (int k = 0; k < int'(NN*NI); k++) wmem[k] = w;
        in_spikes = sp;
        cfg_beta  = b;
        cfg_v_th  = th;
    endtask

    // One full timestep; poke=1 disturbs inputs while busy.
    task automatic run_ts(input string tag, input logic [SIZE-1:0] w, input logic [NI-1:0] sp,
                          input logic [SIZE-1:0] b, input logic [SIZE-1:0] th,
                          input bit clr, input bit poke, input logic [NN-1:0] exp_out);
        int cnt;
        int reads;
        int addr_err;
        load(w, sp, b, th);
        clear_vmem = clr;
        start      = 1'b1;
        @(posedge wb_clk_i); #1;
        start      = 1'b0;
        clear_vmem = 1'b0;
        cnt = 0; reads = 0; addr_err = 0;
        if (weight_re) begin
            if (32'(weight_addr) != 32'(reads)) addr_err++;
            reads++;
        end
        while (!done && cnt < LAT + 100) begin
            if (poke) begin
                case (cnt)
                    10:  begin in_spikes = '0; cfg_beta = '0; cfg_v_th = '0; end
                    50:  clear_vmem = 1'b1;
                    51:  clear_vmem = 1'b0;
                    100: start = 1'b1;
                    101: start = 1'b0;
                    default: ;
                endcase
            end
            @(posedge wb_clk_i); #1;
            cnt++;
            if (weight_re) begin
                if (32'(weight_addr) != 32'(reads)) addr_err++;
                reads++;
            end
        end
        check_eq({tag, "_latency"}, 32'(cnt), 32'(LAT));
        check_eq({tag, "_reads"}, 32'(reads), 32'(NN*NI));
        check_eq({tag, "_addr"}, 32'(addr_err), 32'd0);
        check_eq({tag, "_out"}, 32'(out_spikes), 32'(exp_out));
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge wb_clk_i); #1;
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        bit seen_done;
        wb_rst_i   = 1'b1;
        start      = 1'b0;
        clear_vmem = 1'b0;
        load('0, '0, '0, '0);
        repeat (2) @(posedge wb_clk_i);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_out", 32'(out_spikes), 32'd0);
        check_eq("rst_re", 32'(weight_re), 32'd0);
        check_eq("rst_addr", 32'(weight_addr), 32'd0);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;

        // 4 * 3 = 12 > 10 fires everywhere; 12 vs 12 does not; 24 > 12 does.
        run_ts("t_w3_th10", 8'd3, 16'h000F, 8'd1, 8'd10, 1'b1, 1'b0, 16'hFFFF);
        run_ts("t_w3_th12a", 8'd3, 16'h000F, 8'd1, 8'd12, 1'b0, 1'b0, 16'h0000);
        run_ts("t_w3_th12b", 8'd3, 16'h000F, 8'd1, 8'd12, 1'b0, 1'b0, 16'hFFFF);

        // 200 + 200 wraps to 144; pin it with 144 (no fire) then 143 (fire).
        run_ts("t_wrap", 8'd200, 16'h0003, 8'd1, 8'd255, 1'b0, 1'b0, 16'h0000);
        run_ts("t_wrap_th144", 8'd0, 16'h0000, 8'd1, 8'd144, 1'b0, 1'b0, 16'h0000);
        run_ts("t_wrap_th143", 8'd0, 16'h0000, 8'd1, 8'd143, 1'b0, 1'b0, 16'hFFFF);

        // Build vmem=12, then start+clear together: from zero 3 is not > 3.
        run_ts("t_prefill", 8'd3, 16'h000F, 8'd1, 8'd12, 1'b0, 1'b0, 16'h0000);
        run_ts("t_start_clr", 8'd3, 16'h0001, 8'd1, 8'd3, 1'b1, 1'b0, 16'h0000);

        // Standalone clear in IDLE: leftover 3 would otherwise fire against 0.
        clear_vmem = 1'b1;
        @(posedge wb_clk_i); #1;
        clear_vmem = 1'b0;
        check_eq("clr_no_start", 32'(busy), 32'd0);
        run_ts("t_after_clr", 8'd0, 16'h0000, 8'd1, 8'd0, 1'b0, 1'b0, 16'h0000);

        // Disturbances while busy must not matter: the follow-up run sees 24 > 12.
        run_ts("t_poke", 8'd3, 16'h000F, 8'd1, 8'd12, 1'b0, 1'b1, 16'h0000);
        run_ts("t_poke_chk", 8'd3, 16'h000F, 8'd1, 8'd12, 1'b0, 1'b0, 16'hFFFF);

        // Reset at cycle 300 of a timestep that left vmem=12 in early neurons.
        load(8'd3, 16'h000F, 8'd1, 8'd12);
        start = 1'b1;
        @(posedge wb_clk_i); #1;
        start = 1'b0;
        seen_done = 1'b0;
        repeat (299) begin
            @(posedge wb_clk_i); #1;
            if (done) seen_done = 1'b1;
        end
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        wb_rst_i = 1'b1;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_out", 32'(out_spikes), 32'd0);
        check_eq("mid_rst_re", 32'(weight_re), 32'd0);
        repeat (3) begin
            @(posedge wb_clk_i); #1;
            if (done) seen_done = 1'b1;
        end
        wb_rst_i = 1'b0;
        repeat (2) begin
            @(posedge wb_clk_i); #1;
            if (done) seen_done = 1'b1;
        end
        check_eq("mid_rst_no_done", 32'(seen_done), 32'd0);
        check_eq("post_rst_idle", 32'(busy), 32'd0);
        run_ts("t_after_rst", 8'd3, 16'h000F, 8'd1, 8'd12, 1'b0, 1'b0, 16'h0000);

        // beta=0 zeroes the decayed value, which never exceeds a zero threshold.
        run_ts("t_beta0a", 8'd50, 16'hFFFF, 8'd0, 8'd0, 1'b0, 1'b0, 16'h0000);
        run_ts("t_beta0b", 8'd50, 16'hFFFF, 8'd0, 8'd0, 1'b0, 1'b0, 16'h0000);
        run_ts("t_beta0_vmem", 8'd0, 16'h0000, 8'd1, 8'd0, 1'b0, 1'b0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_sequencer.md
NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 Parameter SIZE, default 8, SHALL set the datapath width of membrane voltage, weight, beta and threshold.
REQ-002 Parameter NUM_NEURONS, default 16, SHALL set the number of neurons time-multiplexed onto one neuron datapath.
REQ-003 Parameter NUM_INPUTS, default 16, SHALL set the number of input spike lines per timestep.
REQ-004 Clock and reset SHALL be: wb_clk_i input 1 clock, single clock domain; wb_rst_i input 1 reset, asynchronous, active-high.
REQ-005 Ports SHALL be:
- start  input  1  begin one timestep.
- clear_vmem  input  1  zero all membrane voltages.
- in_spikes  input  NUM_INPUTS  input spike vector.
- cfg_beta  input  SIZE  decay factor.
- cfg_v_th  input  SIZE  threshold.
- weight_addr  output  log2(NUM_NEURONS*NUM_INPUTS)  weight memory address.
- weight_re  output  1  weight read strobe.
- weight_data  input  SIZE  read data, valid one cycle after weight_re.
- out_spikes  output  NUM_NEURONS  spikes of the last completed timestep.
- busy  output  1  timestep in progress.
- done  output  1  one-cycle completion pulse.

Function
REQ-006 The FSM SHALL have the states IDLE, FETCH, ACCUM, DECAY and DONE.
REQ-007 In IDLE, start=1 SHALL latch in_spikes, cfg_beta and cfg_v_th, set neuron index j=0 and input index i=0, and go to FETCH; busy SHALL be 1 in every state except IDLE.
REQ-008 FETCH SHALL assert weight_re=1 with weight_addr=j*NUM_INPUTS+i, then go to ACCUM.
REQ-009 ACCUM SHALL apply weight_data, vmem[j] and function_sel=0 to the neuron; if latched spike bit i is 1, vmem[j] SHALL take the neuron's v_mem_out, otherwise it is unchanged.
REQ-010 Leaving ACCUM, the FSM SHALL go to DECAY if i==NUM_INPUTS-1, otherwise increment i and go to FETCH.
REQ-011 DECAY SHALL apply function_sel=1 and SHALL write vmem[j] from v_mem_out (0 on spike, else vmem*beta truncated to SIZE bits); the neuron spike SHALL be held in a pending vector at bit j.
REQ-012 Leaving DECAY, the FSM SHALL go to DONE if j==NUM_NEURONS-1, otherwise increment j, clear i and go to FETCH.
REQ-013 DONE SHALL copy the pending vector to out_spikes, pulse done=1 for exactly one cycle, and return to IDLE.
REQ-014 Latency SHALL be fixed: done asserts NUM_NEURONS*(2*NUM_INPUTS+1)+1 cycles after the start-sampling edge (529 at defaults).
REQ-015 Addition and decay SHALL wrap modulo 2^SIZE with no saturation; the spike compare is unsigned and strict (decayed > v_th).
REQ-016 start asserted while busy SHALL be ignored; changes to in_spikes, cfg_beta and cfg_v_th while busy SHALL have no effect.
REQ-017 clear_vmem in IDLE SHALL zero all vmem entries in one cycle; if start and clear_vmem are both 1 in IDLE, the clear SHALL apply first and the timestep SHALL start from zero; clear_vmem while busy SHALL be ignored.
REQ-018 vmem SHALL persist across timesteps until cleared or reset.
REQ-019 weight_re SHALL be 0 outside FETCH, and out_spikes SHALL change only in DONE.

Reset
REQ-020 wb_rst_i=1 SHALL asynchronously force: state IDLE; i=j=0; all vmem and pending bits 0; out_spikes=0; busy=0; done=0; weight_re=0; weight_addr=0.
REQ-021 Reset mid-timestep SHALL abort it with no done pulse, and operation SHALL resume in IDLE on the first edge after deassertion.

Structure
REQ-022 The FSM state encodings and the SIZE, NUM_NEURONS and NUM_INPUTS defaults SHALL live in the shared header snn_defs.
REQ-023 The block SHALL instantiate exactly one existing neuron sub-module (module neuron, SIZE passed through); all other logic is local.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- All weights 3, in_spikes=0x000F, beta=1, v_th=10, one timestep -> vmem=12 then decays to 12, which is >10, so all out_spikes=0xFFFF and vmem=0; done at cycle 529.
- Same with v_th=12 -> out_spikes=0x0000 and vmem stays 12; a second timestep gives 24>12, so out_spikes=0xFFFF.
- Weights 200, in_spikes=0x0003, beta=1, v_th=255 -> vmem wraps to 144 with no spike.
- start pulsed again at cycle 100 of a timestep -> ignored, single done at 529; clear_vmem at cycle 50 ignored.
- wb_rst_i asserted at cycle 300 -> busy=0 and out_spikes=0 immediately, no done; a fresh start then completes normally from vmem=0.
- beta=0, v_th=0, any weights -> decayed=0, not >0, so out_spikes=0 and vmem=0 after every timestep.
